// File: rtl/bank_session_ctrl.sv
// Mobile-banking session sequencer: SIM SMS -> face -> PIN (retry/lockout) -> transaction session.
// One-cycle transaction latency; per-state idle timeouts; balance held across sessions until rst.
module bank_session_ctrl #(
    parameter logic [15:0] STORED_PIN   = 16'h4321,
    parameter logic [15:0] INIT_BALANCE = 16'd8000,
    parameter int          MAX_TRIES    = 3,
    parameter int          TIMEOUT_CYC  = 64,
    parameter int          LOCK_CYC     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sim_sms_received,
    input  logic        face_verified,
    input  logic        pin_strobe,
    input  logic [15:0] user_pin,
    input  logic        txn_req,
    input  logic        txn_type,
    input  logic [15:0] txn_amount,
    input  logic        logout,
    output logic [15:0] balance,
    output logic        access_granted,
    output logic        txn_done,
    output logic        txn_err,
    output logic        locked,
    output logic [3:0]  fail_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SIM_WAIT  = 3'd1,
        S_FACE_WAIT = 3'd2,
        S_PIN_WAIT  = 3'd3,
        S_SESSION   = 3'd4,
        S_LOCKED    = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
    localparam logic [3:0]    TRIES     = 4'(MAX_TRIES);

    state_t         st;
    logic [TW-1:0]  tmo_cnt;
    logic [LW-1:0]  lock_cnt;
    logic [16:0]    dep_sum;
    logic [3:0]     fail_next;
    logic           tmo_hit;

    assign dep_sum   = {1'b0, balance} + {1'b0, txn_amount};
    assign fail_next = fail_count + 4'd1;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    assign state          = st;
    assign access_granted = (st == S_SESSION);
    assign locked         = (st == S_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= S_IDLE;
            balance    <= INIT_BALANCE;
            fail_count <= 4'd0;
            txn_done   <= 1'b0;
            txn_err    <= 1'b0;
            tmo_cnt    <= '0;
            lock_cnt   <= '0;
        end else begin
            txn_done <= 1'b0;
            txn_err  <= 1'b0;
            tmo_cnt  <= tmo_cnt + 1'b1;
            case (st)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (start) st <= S_SIM_WAIT;
                end
                S_SIM_WAIT: begin
                    if (sim_sms_received) begin
                        st      <= S_FACE_WAIT;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        st      <= S_IDLE;
                        tmo_cnt <= '0;
                    end
                end
                S_FACE_WAIT: begin
                    if (face_verified) begin
                        st      <= S_PIN_WAIT;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        st      <= S_IDLE;
                        tmo_cnt <= '0;
                    end
                end
                S_PIN_WAIT: begin
                    if (pin_strobe) begin
                        tmo_cnt <= '0;
                        if (user_pin == STORED_PIN) begin
                            st         <= S_SESSION;
                            fail_count <= 4'd0;
                        end else begin
                            fail_count <= fail_next;
                            if (fail_next == TRIES) begin
                                st       <= S_LOCKED;
                                lock_cnt <= '0;
                            end
                        end
                    end else if (tmo_hit) begin
                        st      <= S_IDLE;
                        tmo_cnt <= '0;
                    end
                end
                S_SESSION: begin
                    // logout beats a same-cycle transaction: nothing applied, no pulse
                    if (logout) begin
                        st      <= S_IDLE;
                        tmo_cnt <= '0;
                    end else if (txn_req) begin
                        tmo_cnt <= '0;
                        if (!txn_type) begin
                            if (txn_amount > balance) begin
                                txn_err <= 1'b1;
                            end else begin
                                balance  <= balance - txn_amount;
                                txn_done <= 1'b1;
                            end
                        end else begin
                            if (dep_sum[16]) begin
                                txn_err <= 1'b1;
                            end else begin
                                balance  <= dep_sum[15:0];
                                txn_done <= 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        st      <= S_IDLE;
                        tmo_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    tmo_cnt <= '0;
                    if (lock_cnt == LOCK_LAST) begin
                        st         <= S_IDLE;
                        fail_count <= 4'd0;
                        lock_cnt   <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    st      <= S_IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_session_ctrl.sv
// Bench for bank_session_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_bank_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sim_sms_received, face_verified, pin_strobe;
    logic [15:0] user_pin;
    logic        txn_req, txn_type, logout;
    logic [15:0] txn_amount;
    logic [15:0] balance;
    logic        access_granted, txn_done, txn_err, locked;
    logic [3:0]  fail_count;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    // Reference model: mode numbers are the spec's state encodings
    int m_mode, m_bal, m_fail, m_idle, m_lock_left;
    bit m_done, m_err;

    bank_session_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .sim_sms_received(sim_sms_received),
        .face_verified(face_verified), .pin_strobe(pin_strobe), .user_pin(user_pin),
        .txn_req(txn_req), .txn_type(txn_type), .txn_amount(txn_amount), .logout(logout),
        .balance(balance), .access_granted(access_granted), .txn_done(txn_done),
        .txn_err(txn_err), .locked(locked), .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_bal = 8000; m_fail = 0; m_idle = 0; m_lock_left = 0;
        m_done = 0; m_err = 0;
    endtask

    task automatic model_waited(input bit ev, input int nxt);
        if (ev) begin
            m_mode = nxt; m_idle = 0;
        end else if (m_idle == 63) begin
            m_mode = 0; m_idle = 0;
        end else begin
            m_idle++;
        end
    endtask

    task automatic model_update();
        m_done = 0; m_err = 0;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_idle = 0; end
            1: model_waited(sim_sms_received, 2);
            2: model_waited(face_verified, 3);
            3: begin
                if (pin_strobe) begin
                    m_idle = 0;
                    if (user_pin == 16'h4321) begin
                        m_mode = 4; m_fail = 0;
                    end else begin
                        m_fail++;
                        if (m_fail == 3) begin m_mode = 5; m_lock_left = 256; end
                    end
                end else model_waited(1'b0, 3);
            end
            4: begin
                if (logout) begin
                    m_mode = 0; m_idle = 0;
                end else if (txn_req) begin
                    m_idle = 0;
                    if (txn_type == 1'b0) begin
                        if (int'(txn_amount) > m_bal) m_err = 1;
                        else begin m_bal -= int'(txn_amount); m_done = 1; end
                    end else begin
                        if (m_bal + int'(txn_amount) > 65535) m_err = 1;
                        else begin m_bal += int'(txn_amount); m_done = 1; end
                    end
                end else model_waited(1'b0, 4);
            end
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_mode = 0; m_fail = 0; end
            end
        endcase
    endtask

    task automatic clear_inputs();
        start = 0; sim_sms_received = 0; face_verified = 0; pin_strobe = 0;
        user_pin = 16'h0; txn_req = 0; txn_type = 0; txn_amount = 16'h0; logout = 0;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic reach_pin_wait();
        start = 1; tick(); clear_inputs();
        sim_sms_received = 1; tick(); clear_inputs();
        face_verified = 1; tick(); clear_inputs();
    endtask

    task automatic enter_pin(input logic [15:0] p);
        pin_strobe = 1; user_pin = p; tick(); clear_inputs();
    endtask

    task automatic do_txn(input logic ty, input logic [15:0] amt);
        txn_req = 1; txn_type = ty; txn_amount = amt; tick(); clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (state !== 3'd0 || balance !== 16'd8000 || fail_count !== 4'd0 || access_granted !== 1'b0 ||
            txn_done !== 1'b0 || txn_err !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d bal=%0d fail=%0d ag=%b done=%b err=%b lk=%b want 0/8000/0/0/0/0/0",
                     state, balance, fail_count, access_granted, txn_done, txn_err, locked);
        end
    endtask

    task automatic test_happy_path();
        logic [2:0] exp_st;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: start = 1;
                1: sim_sms_received = 1;
                2: face_verified = 1;
                default: begin pin_strobe = 1; user_pin = 16'h4321; end
            endcase
            tick(); clear_inputs();
            exp_st = 3'(i + 1);
            checks++;
            if (state !== exp_st) begin
                errors++; $display("FAIL happy_step%0d: state=%0d want %0d", i, state, exp_st);
            end
        end
        checks++;
        if (access_granted !== 1'b1 || balance !== 16'd8000) begin
            errors++; $display("FAIL happy_session: ag=%b bal=%0d want 1/8000", access_granted, balance);
        end
    endtask

    task automatic test_transactions();
        do_txn(1'b0, 16'd3000);
        checks++;
        if (balance !== 16'd5000 || txn_done !== 1'b1 || txn_err !== 1'b0) begin
            errors++; $display("FAIL txn_withdraw: bal=%0d done=%b err=%b want 5000/1/0", balance, txn_done, txn_err);
        end
        tick();
        checks++;
        if (txn_done !== 1'b0) begin
            errors++; $display("FAIL txn_pulse_width: done=%b want 0", txn_done);
        end
        do_txn(1'b1, 16'd500);
        checks++;
        if (balance !== 16'd5500 || txn_done !== 1'b1) begin
            errors++; $display("FAIL txn_deposit: bal=%0d done=%b want 5500/1", balance, txn_done);
        end
        do_txn(1'b0, 16'd6000);
        checks++;
        if (balance !== 16'd5500 || txn_err !== 1'b1 || txn_done !== 1'b0) begin
            errors++; $display("FAIL txn_overdraw: bal=%0d done=%b err=%b want 5500/0/1", balance, txn_done, txn_err);
        end
    endtask

    task automatic test_lockout();
        logic [3:0] exp_f;
        do_reset();
        reach_pin_wait();
        for (int i = 1; i <= 3; i++) begin
            enter_pin(16'h1111);
            exp_f = 4'(i);
            checks++;
            if (fail_count !== exp_f) begin
                errors++; $display("FAIL lock_fail%0d: fail_count=%0d want %0d", i, fail_count, exp_f);
            end
        end
        checks++;
        if (locked !== 1'b1 || state !== 3'd5) begin
            errors++; $display("FAIL lock_enter: locked=%b state=%0d want 1/5", locked, state);
        end
        start = 1;
        repeat (255) tick();
        checks++;
        if (locked !== 1'b1 || state !== 3'd5) begin
            errors++; $display("FAIL lock_hold: locked=%b state=%0d want 1/5", locked, state);
        end
        tick();
        clear_inputs();
        checks++;
        if (state !== 3'd0 || locked !== 1'b0 || fail_count !== 4'd0) begin
            errors++; $display("FAIL lock_expire: state=%0d locked=%b fail=%0d want 0/0/0", state, locked, fail_count);
        end
    endtask

    task automatic test_retry_recovery();
        reach_pin_wait();
        enter_pin(16'h1111);
        enter_pin(16'hBEEF);
        checks++;
        if (fail_count !== 4'd2 || state !== 3'd3) begin
            errors++; $display("FAIL retry_two_wrong: fail=%0d state=%0d want 2/3", fail_count, state);
        end
        enter_pin(16'h4321);
        checks++;
        if (state !== 3'd4 || fail_count !== 4'd0 || access_granted !== 1'b1) begin
            errors++; $display("FAIL retry_ok: state=%0d fail=%0d ag=%b want 4/0/1", state, fail_count, access_granted);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1; tick(); clear_inputs();
        sim_sms_received = 1; tick(); clear_inputs();
        repeat (63) tick();
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL tmo_face_early: state=%0d want 2", state);
        end
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL tmo_face: state=%0d want 0", state);
        end
        reach_pin_wait();
        enter_pin(16'h4321);
        repeat (63) tick();
        checks++;
        if (state !== 3'd4) begin
            errors++; $display("FAIL tmo_session_early: state=%0d want 4", state);
        end
        tick();
        checks++;
        if (state !== 3'd0 || access_granted !== 1'b0) begin
            errors++; $display("FAIL tmo_session: state=%0d ag=%b want 0/0", state, access_granted);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        reach_pin_wait();
        enter_pin(16'h4321);
        do_txn(1'b1, 16'hFFFF);
        checks++;
        if (txn_err !== 1'b1 || txn_done !== 1'b0 || balance !== 16'd8000) begin
            errors++; $display("FAIL bnd_dep_ovf: err=%b done=%b bal=%0d want 1/0/8000", txn_err, txn_done, balance);
        end
        logout = 1; txn_req = 1; txn_type = 0; txn_amount = 16'd100; tick(); clear_inputs();
        checks++;
        if (state !== 3'd0 || balance !== 16'd8000 || txn_done !== 1'b0 || txn_err !== 1'b0) begin
            errors++; $display("FAIL bnd_logout_txn: state=%0d bal=%0d done=%b err=%b want 0/8000/0/0",
                               state, balance, txn_done, txn_err);
        end
        reach_pin_wait();
        enter_pin(16'h4321);
        do_txn(1'b0, 16'd8000);
        checks++;
        if (balance !== 16'd0 || txn_done !== 1'b1) begin
            errors++; $display("FAIL bnd_withdraw_all: bal=%0d done=%b want 0/1", balance, txn_done);
        end
        do_txn(1'b1, 16'd0);
        checks++;
        if (balance !== 16'd0 || txn_done !== 1'b1 || txn_err !== 1'b0) begin
            errors++; $display("FAIL bnd_zero_amt: bal=%0d done=%b err=%b want 0/1/0", balance, txn_done, txn_err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || balance !== 16'd8000 || access_granted !== 1'b0) begin
            errors++; $display("FAIL bnd_async_rst: state=%0d bal=%0d ag=%b want 0/8000/0", state, balance, access_granted);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            start            = ($urandom_range(0, 3) == 0);
            sim_sms_received = ($urandom_range(0, 3) == 0);
            face_verified    = ($urandom_range(0, 3) == 0);
            pin_strobe       = ($urandom_range(0, 3) == 0);
            user_pin         = ($urandom_range(0, 2) != 0) ? 16'h4321 : 16'($urandom);
            txn_req          = ($urandom_range(0, 1) == 0);
            txn_type         = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       txn_amount = 16'd0;
                1:       txn_amount = 16'($urandom_range(0, 2000));
                2:       txn_amount = 16'(m_bal);
                default: txn_amount = 16'($urandom);
            endcase
            logout = ($urandom_range(0, 31) == 0);
            tick();
            checks++;
            if (state !== 3'(m_mode) || balance !== 16'(m_bal) || fail_count !== 4'(m_fail) ||
                txn_done !== m_done || txn_err !== m_err ||
                access_granted !== (m_mode == 4) || locked !== (m_mode == 5)) begin
                errors++;
                $display("FAIL rand_cyc%0d: st=%0d bal=%0d f=%0d d=%b e=%b ag=%b lk=%b want st=%0d bal=%0d f=%0d d=%b e=%b",
                         cyc, state, balance, fail_count, txn_done, txn_err, access_granted, locked,
                         m_mode, m_bal, m_fail, m_done, m_err);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_happy_path();
        test_transactions();
        test_lockout();
        test_retry_recovery();
        test_timeout();
        test_boundaries();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
